pool_sched: RTL

POOL_SCHED -- requirements
Module: pool_sched

---
 rtl/pool_sched_pkg.sv | 17 +
 rtl/pool_sched_win_counter.sv | 56 +++++
 rtl/pool_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pool_sched_pkg.sv
// Shared types and constants for the pooling scheduler.
package pool_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_A    = 3'd1,
        GET_B    = 3'd2,
        ISSUE_A  = 3'd3,
        ISSUE_B  = 3'd4,
        WAIT_SUM = 3'd5,
        EMIT     = 3'd6,
        FINISH   = 3'd7
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/pool_sched_win_counter.sv
// Window/strip position tracker. last_col flags the final window of the current strip,
// last_win flags that the current strip is the final strip, so both together mark the job's last window.
module pool_win_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] num_cols,
    input  logic [CNT_W-1:0] num_strips,
    output logic             last_col,
    output logic             last_win
);

    logic [CNT_W-1:0] cols_q;
    logic [CNT_W-1:0] strips_q;
    logic [CNT_W-1:0] col_cnt;
    logic [CNT_W-1:0] strip_cnt;
    logic [CNT_W-1:0] col_nx;
    logic [CNT_W-1:0] strip_nx;

    // Column position advances two per window and wraps into the next strip.
    always_comb begin
        col_nx   = col_cnt + CNT_W'(2);
        strip_nx = strip_cnt;
        if (last_col) begin
            col_nx   = '0;
            strip_nx = strip_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cols_q    <= '0;
            strips_q  <= '0;
            col_cnt   <= '0;
            strip_cnt <= '0;
            last_col  <= 1'b0;
            last_win  <= 1'b0;
        end else if (load) begin
            cols_q    <= num_cols;
            strips_q  <= num_strips;
            col_cnt   <= '0;
            strip_cnt <= '0;
            last_col  <= (num_cols == CNT_W'(2));
            last_win  <= (num_strips == CNT_W'(1));
        end else if (step) begin
            col_cnt   <= col_nx;
            strip_cnt <= strip_nx;
            last_col  <= (col_nx == cols_q - CNT_W'(2));
            last_win  <= (strip_nx == strips_q - CNT_W'(1));
        end
    end

endmodule

// File: rtl/pool_sched.sv
// Pooling scheduler: gathers column pairs, feeds them to a reduction unit and streams pooled sums.
// Optional WAIT_SUM watchdog enabled by defining POOL_SCHED_TIMEOUT_EN.
module pool_sched
    import pool_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAT_HEIGHT = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [CNT_W-1:0]                     num_cols,
    input  logic [CNT_W-1:0]                     num_strips,
    input  logic                                 in_valid,
    input  logic [MAT_HEIGHT-1:0][DATA_WIDTH-1:0] in_col,
    output logic                                 in_ready,
    output logic                                 red_valid_in,
    output logic [MAT_HEIGHT-1:0][DATA_WIDTH-1:0] red_column,
    input  logic                                 red_valid_out,
    input  logic [DATA_WIDTH-1:0]                red_sum,
    output logic                                 out_valid,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 out_last,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    state_t state;
    state_t state_next;

    logic [MAT_HEIGHT-1:0][DATA_WIDTH-1:0] buf_a;
    logic [MAT_HEIGHT-1:0][DATA_WIDTH-1:0] buf_b;
    logic                                  wait_armed;
    logic                                  cfg_bad;
    logic                                  start_ok;
    logic                                  in_hs;
    logic                                  out_hs;
    logic                                  capture;
    logic                                  timeout;
    logic                                  last_col;
    logic                                  last_win;

    logic                                  in_ready_d;
    logic                                  red_valid_in_d;
    logic [MAT_HEIGHT-1:0][DATA_WIDTH-1:0] red_column_d;
    logic                                  out_valid_d;
    logic                                  out_last_d;
    logic                                  busy_d;
    logic                                  done_d;

    assign cfg_bad  = (num_cols == '0) || num_cols[0] || (num_strips == '0);
    assign start_ok = (state == IDLE) && start && !cfg_bad;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    // The first WAIT_SUM cycle may still see the previous window's valid, so it is skipped.
    assign capture  = (state == WAIT_SUM) && wait_armed && red_valid_out;

`ifdef POOL_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt;

    assign timeout = (state == WAIT_SUM) && !capture && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state != WAIT_SUM) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    pool_win_counter #(
        .CNT_W(CNT_W)
    ) u_win_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (start_ok),
        .step      (out_hs),
        .num_cols  (num_cols),
        .num_strips(num_strips),
        .last_col  (last_col),
        .last_win  (last_win)
    );

    // State register; outputs are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            red_valid_in <= 1'b0;
            red_column   <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            in_ready     <= in_ready_d;
            red_valid_in <= red_valid_in_d;
            red_column   <= red_column_d;
            out_valid    <= out_valid_d;
            out_last     <= out_last_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start_ok) state_next = GET_A;
            GET_A:    if (in_hs) state_next = GET_B;
            GET_B:    if (in_hs) state_next = ISSUE_A;
            ISSUE_A:  state_next = ISSUE_B;
            ISSUE_B:  state_next = WAIT_SUM;
            WAIT_SUM: begin
                if (capture)      state_next = EMIT;
                else if (timeout) state_next = FINISH;
            end
            EMIT:     if (out_hs) state_next = (last_col && last_win) ? FINISH : GET_A;
            FINISH:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d     = 1'b0;
        red_valid_in_d = 1'b0;
        red_column_d   = '0;
        out_valid_d    = 1'b0;
        out_last_d     = 1'b0;
        done_d         = 1'b0;
        busy_d         = (state_next != IDLE);
        case (state_next)
            GET_A, GET_B: in_ready_d = 1'b1;
            ISSUE_A: begin
                red_valid_in_d = 1'b1;
                red_column_d   = buf_a;
            end
            ISSUE_B:      red_column_d = buf_b;
            EMIT: begin
                out_valid_d = 1'b1;
                out_last_d  = last_col && last_win;
            end
            FINISH:       done_d = 1'b1;
            default: ;
        endcase
    end

    // Column buffers, captured sum and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_a      <= '0;
            buf_b      <= '0;
            out_data   <= '0;
            wait_armed <= 1'b0;
            err        <= 1'b0;
        end else begin
            wait_armed <= (state == WAIT_SUM);
            if (state == GET_A && in_hs) buf_a <= in_col;
            if (state == GET_B && in_hs) buf_b <= in_col;
            if (capture) out_data <= red_sum;
            if (state == IDLE && start) begin
                err <= cfg_bad;
            end else if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule
